// File: rtl/fpm_pkg.sv
// Shared constants for the FP32 multiplier result buffer: field widths, class codes,
// flag bit positions, the stored entry layout and a saturating increment helper.
package fpm_pkg;

    localparam int FP32_EXP_W = 8;
    localparam int FP32_MAN_W = 23;

    localparam logic [2:0] CLS_NORM = 3'd0;
    localparam logic [2:0] CLS_ZERO = 3'd1;
    localparam logic [2:0] CLS_SUB  = 3'd2;
    localparam logic [2:0] CLS_INF  = 3'd3;
    localparam logic [2:0] CLS_NAN  = 3'd4;

    localparam int FLG_ZERO = 0;
    localparam int FLG_SUB  = 1;
    localparam int FLG_INF  = 2;
    localparam int FLG_NAN  = 3;

    typedef struct packed {
        logic [2:0]  cls;
        logic [31:0] data;
    } fpm_entry_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/fp32_classify.sv
// Combinational IEEE-754 single-precision classifier; the sign bit does not affect the class.
module fp32_classify
    import fpm_pkg::*;
(
    input  logic [31:0] data_i,
    output logic [2:0]  cls_o
);

    logic [FP32_EXP_W-1:0] exp_w;
    logic [FP32_MAN_W-1:0] man_w;

    assign exp_w = data_i[30:23];
    assign man_w = data_i[22:0];

    always_comb begin
        cls_o = CLS_NORM;
        if (exp_w == '1) begin
            cls_o = (man_w != '0) ? CLS_NAN : CLS_INF;
        end else if (exp_w == '0) begin
            cls_o = (man_w != '0) ? CLS_SUB : CLS_ZERO;
        end
    end

endmodule

// File: rtl/fpm_result_buffer.sv
// FWFT result FIFO behind the FP32 multiplier: classifies, queues, counts drops, keeps sticky flags.
// Optional per-class statistics counters are built when FPM_RESULT_STATS_EN is defined.
module fpm_result_buffer
    import fpm_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DROP_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [31:0]                in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_data,
    output logic [2:0]                 out_class,
    output logic [$clog2(DEPTH):0]     level,
    input  logic                       clear_flags,
    output logic [3:0]                 flags,
    output logic [DROP_W-1:0]          drop_cnt
`ifdef FPM_RESULT_STATS_EN
    ,
    output logic [15:0]                stat_nan_cnt,
    output logic [15:0]                stat_inf_cnt,
    output logic [15:0]                stat_norm_cnt
`endif
);

    localparam int ADDR_W = $clog2(DEPTH);

    fpm_entry_t        mem_q [DEPTH];
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [3:0]        flags_q, flags_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic [2:0]        in_cls;
    logic              full, empty, pop, push_ok;

    fp32_classify u_classify (
        .data_i (in_data),
        .cls_o  (in_cls)
    );

    // Extra pointer MSB distinguishes full from empty when the address bits match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                     (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign pop     = !empty && out_ready;
    assign push_ok = in_valid && (!full || pop);

    assign out_valid = !empty;
    assign level     = wr_ptr_q - rd_ptr_q;
    assign out_data  = mem_q[rd_ptr_q[ADDR_W-1:0]].data;
    assign out_class = mem_q[rd_ptr_q[ADDR_W-1:0]].cls;
    assign flags     = flags_q;
    assign drop_cnt  = drop_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + (push_ok ? 1'b1 : 1'b0);
        rd_ptr_d = rd_ptr_q + (pop ? 1'b1 : 1'b0);

        drop_d = drop_q;
        if (in_valid && !push_ok && (drop_q != '1)) begin
            drop_d = drop_q + 1'b1;
        end

        // Clear first so a same-cycle set of a bit still lands.
        flags_d = clear_flags ? 4'b0000 : flags_q;
        if (push_ok) begin
            unique case (in_cls)
                CLS_ZERO: flags_d[FLG_ZERO] = 1'b1;
                CLS_SUB:  flags_d[FLG_SUB]  = 1'b1;
                CLS_INF:  flags_d[FLG_INF]  = 1'b1;
                CLS_NAN:  flags_d[FLG_NAN]  = 1'b1;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            flags_q  <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            flags_q  <= flags_d;
            drop_q   <= drop_d;
        end
    end

    // Storage is never reset; out_* are only meaningful while out_valid is high.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= '{cls: in_cls, data: in_data};
        end
    end

`ifdef FPM_RESULT_STATS_EN
    logic [15:0] nan_q, nan_d;
    logic [15:0] inf_q, inf_d;
    logic [15:0] norm_q, norm_d;

    always_comb begin
        nan_d  = clear_flags ? 16'd0 : nan_q;
        inf_d  = clear_flags ? 16'd0 : inf_q;
        norm_d = clear_flags ? 16'd0 : norm_q;
        if (push_ok) begin
            if (in_cls == CLS_NAN)  nan_d  = sat_inc16(nan_d);
            if (in_cls == CLS_INF)  inf_d  = sat_inc16(inf_d);
            if (in_cls == CLS_NORM) norm_d = sat_inc16(norm_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nan_q  <= '0;
            inf_q  <= '0;
            norm_q <= '0;
        end else begin
            nan_q  <= nan_d;
            inf_q  <= inf_d;
            norm_q <= norm_d;
        end
    end

    assign stat_nan_cnt  = nan_q;
    assign stat_inf_cnt  = inf_q;
    assign stat_norm_cnt = norm_q;
`endif

endmodule

// File: tb/tb_fpm_result_buffer.sv
// Directed self-checking bench for fpm_result_buffer; covers stats outputs when FPM_RESULT_STATS_EN is set.
module tb_fpm_result_buffer;

    localparam int DEPTH  = 8;
    localparam int DROP_W = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_class;
    logic [3:0]  level;
    logic        clear_flags;
    logic [3:0]  flags;
    logic [15:0] drop_cnt;
`ifdef FPM_RESULT_STATS_EN
    logic [15:0] stat_nan_cnt, stat_inf_cnt, stat_norm_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q [DEPTH];

    fpm_result_buffer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_class   (out_class),
        .level       (level),
        .clear_flags (clear_flags),
        .flags       (flags),
        .drop_cnt    (drop_cnt)
`ifdef FPM_RESULT_STATS_EN
        ,
        .stat_nan_cnt  (stat_nan_cnt),
        .stat_inf_cnt  (stat_inf_cnt),
        .stat_norm_cnt (stat_norm_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then stable 1 time unit past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clear_flags = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_level", level, 0);
        check("rst_valid", out_valid, 0);
        check("rst_flags", flags, 0);
        check("rst_drop",  drop_cnt, 0);

        // First write visible one cycle later.
        push(32'h3F80_0000);
        check("first_valid", out_valid, 1);
        check("first_data",  out_data, 32'h3F80_0000);
        check("first_class", out_class, 0);
        check("first_level", level, 1);

        // Overfill with no consumer: two words dropped, head unchanged.
        do_reset();
        check("reset2_level", level, 0);
        for (int i = 0; i < DEPTH + 2; i++) begin
            push(32'h4000_0000 + i);
        end
        check("fill_level", level, DEPTH);
        check("fill_drop",  drop_cnt, 2);
        check("fill_head",  out_data, 32'h4000_0000);
        check("fill_flags", flags, 0);

        // Full with simultaneous push and pop.
        in_valid = 1'b1; in_data = 32'h4100_0000; out_ready = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        check("fullpp_level", level, DEPTH);
        check("fullpp_drop",  drop_cnt, 2);
        for (int i = 0; i < DEPTH - 1; i++) exp_q[i] = 32'h4000_0001 + i;
        exp_q[DEPTH-1] = 32'h4100_0000;
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("drain_%0d", i), out_data, exp_q[i]);
            step();
        end
        out_ready = 1'b0;
        check("drain_valid", out_valid, 0);
        check("drain_level", level, 0);

        // out_ready while empty changes nothing.
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("empty_pop_level", level, 0);

        // Classification and sticky flags.
        push(32'h7FC0_0000);
        push(32'h7F80_0000);
        push(32'h0000_0001);
        push(32'h8000_0000);
        check("cls_flags", flags, 4'b1111);
        check("cls_level", level, 4);
        out_ready = 1'b1;
        check("cls_nan", out_class, 4); step();
        check("cls_inf", out_class, 3); step();
        check("cls_sub", out_class, 2); step();
        check("cls_zero", out_class, 1); step();
        out_ready = 1'b0;
        check("cls_empty", out_valid, 0);
        clear_flags = 1'b1;
        push(32'h0000_0000);
        check("clr_set_flags", flags, 4'b0001);
        check("clr_zero_class", out_class, 1);
        step();
        clear_flags = 1'b0;
        check("clr_only_flags", flags, 4'b0000);

        // Reset mid-stream drops queued entries; in_valid ignored during reset.
        do_reset();
        for (int i = 0; i < 5; i++) push(32'h3F00_0000 + i);
        check("mid_level5", level, 5);
        rst = 1'b1; in_valid = 1'b1; in_data = 32'h7F80_0000;
        step();
        rst = 1'b0; in_valid = 1'b0;
        check("mid_rst_level", level, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_flags", flags, 0);

        // Drop counter saturation; dropped NaNs must not set flags.
        for (int i = 0; i < DEPTH; i++) push(32'h3F80_0000);
        in_valid = 1'b1; in_data = 32'h7FC0_0000;
        for (int i = 0; i < 65535; i++) step();
        check("sat_drop", drop_cnt, 16'hFFFF);
        step();
        in_valid = 1'b0;
        check("sat_hold", drop_cnt, 16'hFFFF);
        check("sat_flags", flags, 0);
        check("sat_level", level, DEPTH);

`ifdef FPM_RESULT_STATS_EN
        do_reset();
        check("st_rst_nan", stat_nan_cnt, 0);
        for (int i = 0; i < 5; i++) push(32'h3F80_0000);
        for (int i = 0; i < 3; i++) push(32'h7FC0_0000);
        push(32'h7FC0_0001);
        check("st_nan", stat_nan_cnt, 3);
        check("st_norm", stat_norm_cnt, 5);
        check("st_inf", stat_inf_cnt, 0);
        check("st_drop", drop_cnt, 1);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        clear_flags = 1'b1;
        push(32'h7FC0_0000);
        clear_flags = 1'b0;
        check("st_clr_nan", stat_nan_cnt, 1);
        check("st_clr_norm", stat_norm_cnt, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
